sync_fifo_ram: RTL and testbench
================================

SYNC_FIFO_RAM -- requirements
Module: sync_fifo_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: depth = 2**ADDR_WIDTH words (256).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port wr_en, input, 1: write request.
REQ-006 SHALL have port din, input, DATA_WIDTH: write data.
REQ-007 SHALL have port rd_en, input, 1: read request.
REQ-008 SHALL have port dout, output, DATA_WIDTH: read data, registered.
REQ-009 SHALL have port dout_valid, output, 1: dout holds a newly popped word this cycle.
REQ-010 SHALL have port full, output, 1: count == depth.
REQ-011 SHALL have port empty, output, 1: count == 0.
REQ-012 SHALL have port count, output, ADDR_WIDTH+1: stored word count, 0..depth.
REQ-013 SHALL have port overflow, output, 1: one-cycle pulse on a rejected write.
REQ-014 SHALL have port underflow, output, 1: one-cycle pulse on a rejected read.

Function
REQ-015 A write SHALL be accepted when wr_en=1 and (full=0 or an accepted read occurs in the same cycle).
REQ-016 An accepted write SHALL store din at wr_ptr, then wr_ptr SHALL increment modulo depth.
REQ-017 A read SHALL be accepted when rd_en=1 and empty=0.
REQ-018 An accepted read SHALL take the word at rd_ptr, then rd_ptr SHALL increment modulo depth.
REQ-019 Read latency SHALL be 1 cycle: the word appears on dout with dout_valid=1 in the cycle after acceptance.
REQ-020 dout SHALL hold its last value while dout_valid=0.
REQ-021 count SHALL update each cycle: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-022 full, empty and count SHALL be registered and consistent in the same cycle.
REQ-023 Both pointers SHALL wrap from depth-1 to 0 with no loss of data ordering.
REQ-024 When full and wr_en=1 with no accepted read, the write SHALL be dropped, memory SHALL stay unchanged, and overflow SHALL be 1 for one cycle.
REQ-025 When empty and rd_en=1, the read SHALL be rejected, underflow SHALL be 1 for one cycle, and dout_valid SHALL stay 0.
REQ-026 When empty with rd_en=1 and wr_en=1, the write SHALL be accepted, the read rejected and underflow asserted; the new word SHALL NOT be bypassed to dout.
REQ-027 When full with rd_en=1 and wr_en=1, both SHALL be accepted and count SHALL remain depth.
REQ-028 When rd_ptr equals wr_ptr with simultaneous read and write, the read SHALL return the old stored word (read-before-write).

Reset
REQ-029 Asserting rst at any time, including mid-transfer, SHALL immediately clear wr_ptr, rd_ptr, count, dout, dout_valid, overflow and underflow to 0, and set empty=1 and full=0.
REQ-030 Memory contents SHALL NOT be cleared by rst; stale words SHALL be unreachable after reset.
REQ-031 The first request SHALL be accepted on the first rising clk edge after rst deasserts.

Configuration
REQ-032 With macro FIFO_ALMOST_FLAGS_EN defined, the block SHALL add parameters AF_LEVEL (default depth-4) and AE_LEVEL (default 4), and registered outputs almost_full (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL), reset to 0 and 1 respectively.
REQ-033 Without FIFO_ALMOST_FLAGS_EN, those parameters and ports SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 Default widths and the derived depth/count-width calculations SHALL live in the shared header fifo_pkg.vh.
REQ-035 Storage SHALL be a sub-module dp_ram: a parametrised simple dual-port RAM with DATA_WIDTH/ADDR_WIDTH, separate read_addr/write_addr, we, din, and registered dout.
REQ-036 Pointer, count and flag control SHALL reside in sync_fifo_ram.

Verification
REQ-037 Write 16'haaaa, 16'hbbbb, 16'hcccc, then read 3 -> dout shows aaaa, bbbb, cccc, each one cycle after its read, with dout_valid=1; empty=1 at the end.
REQ-038 Write 256 words 0..255 -> full=1 and count=256; a 257th write -> overflow pulse; reading all 256 returns 0..255 in order.
REQ-039 Read when empty -> underflow=1 for one cycle, dout_valid=0, count=0.
REQ-040 When full, assert rd_en and wr_en together with din=16'h1234 for 1 cycle -> count stays 256, 16'h1234 is read last after wrap-around.
REQ-041 Write 5 words, assert rst mid-read -> count=0, empty=1, dout=0 immediately; a subsequent write/read of 16'hdddd returns 16'hdddd.
REQ-042 With FIFO_ALMOST_FLAGS_EN, fill to 252 -> almost_full=1; drain to 4 -> almost_empty=1.

Source files
------------

// File: rtl/sync_fifo_ram_pkg.sv
// Shared defaults for the RAM-backed synchronous FIFO: word/address widths
// and the derived depth and count-width helpers.
// No ports. Optional almost-full/empty flags are gated by FIFO_ALMOST_FLAGS_EN.
package sync_fifo_ram_pkg;

   localparam int FIFO_DATA_WIDTH = 16;
   localparam int FIFO_ADDR_WIDTH = 8;

   // Number of words addressable with aw address bits.
   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

   // Count has to represent 0..depth inclusive, hence one extra bit.
   function automatic int fifo_cnt_width(input int aw);
      return aw + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_ram_dp_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
// Latency: dout updates on the clock edge that samples re; holds otherwise.
// Ports: clk, rst (async, clears only dout), we/write_addr/din, re/read_addr, dout.
module dp_ram
   import sync_fifo_ram_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem [0:fifo_depth(ADDR_WIDTH)-1];

   // Storage is never reset; the FIFO pointers make stale words unreachable.
   always_ff @(posedge clk) begin
      if (we)
         mem[write_addr] <= din;
   end

   // Non-blocking update gives read-before-write on an address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         dout <= '0;
      else if (re)
         dout <= mem[read_addr];
   end

endmodule

// File: rtl/sync_fifo_ram.sv
// Synchronous FIFO over dp_ram with registered count/full/empty and
// overflow/underflow pulses. Read latency 1 cycle (dout + dout_valid).
// Backpressure: writes dropped when full unless a read is accepted the same cycle.
// Ports: clk, rst (async active-high), wr_en/din, rd_en, dout/dout_valid,
// full, empty, count, overflow, underflow; almost_full/almost_empty and
// AF_LEVEL/AE_LEVEL exist only when FIFO_ALMOST_FLAGS_EN is defined.
module sync_fifo_ram
   import sync_fifo_ram_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
`ifdef FIFO_ALMOST_FLAGS_EN
   ,
   parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 4,
   parameter int AE_LEVEL   = 4
`endif
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
`ifdef FIFO_ALMOST_FLAGS_EN
   output logic                  almost_full,
   output logic                  almost_empty,
`endif
   output logic                  overflow,
   output logic                  underflow
);

   localparam int            CW        = fifo_cnt_width(ADDR_WIDTH);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(fifo_depth(ADDR_WIDTH));

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  rd_acc;
   logic                  wr_acc;
   logic [CW-1:0]         count_nxt;

   // A read frees a slot in the same cycle, so a full FIFO still takes a write
   // alongside it. An empty FIFO never bypasses din to dout.
   assign rd_acc = rd_en & ~empty;
   assign wr_acc = wr_en & (~full | rd_acc);

   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc)
            rd_ptr <= rd_ptr + 1'b1;
         count      <= count_nxt;
         full       <= (count_nxt == DEPTH_CNT);
         empty      <= (count_nxt == '0);
         dout_valid <= rd_acc;
         overflow   <= wr_en & ~wr_acc;
         underflow  <= rd_en & empty;
      end
   end

`ifdef FIFO_ALMOST_FLAGS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         almost_full  <= (count_nxt >= CW'(AF_LEVEL));
         almost_empty <= (count_nxt <= CW'(AE_LEVEL));
      end
   end
`endif

   dp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk        (clk),
      .rst        (rst),
      .we         (wr_acc),
      .write_addr (wr_ptr),
      .din        (din),
      .re         (rd_acc),
      .read_addr  (rd_ptr),
      .dout       (dout)
   );

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed bench for sync_fifo_ram (default 16-bit x 256 words).
// Inputs change on the falling edge; outputs sampled 1 time unit after the rising edge.
// Almost-flag checks are compiled in only with FIFO_ALMOST_FLAGS_EN.
module tb_sync_fifo_ram;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [15:0] din;
   logic        rd_en;
   logic [15:0] dout;
   logic        dout_valid;
   logic        full;
   logic        empty;
   logic [8:0]  count;
   logic        overflow;
   logic        underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
   logic        almost_full;
   logic        almost_empty;
`endif

   int n_cmp;
   int n_bad;

   sync_fifo_ram dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .din          (din),
      .rd_en        (rd_en),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .full         (full),
      .empty        (empty),
      .count        (count),
`ifdef FIFO_ALMOST_FLAGS_EN
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
`endif
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock of stimulus; returns 1 unit after the rising edge.
   task automatic cyc(input logic w, input logic [15:0] d, input logic r);
      @(negedge clk);
      wr_en = w;
      din   = d;
      rd_en = r;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
      #1;
      n_cmp++;
      if ({count, empty, full, dout_valid, overflow, underflow} !== {9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_flags: count=%0d empty=%b full=%b dv=%b ovf=%b udf=%b, want 0 1 0 0 0 0",
                  count, empty, full, dout_valid, overflow, underflow);
      end
      n_cmp++;
      if (dout !== 16'h0000) begin
         n_bad++; $display("FAIL reset_dout: got %h want 0000", dout);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [15:0] exp [3];
      exp[0] = 16'haaaa; exp[1] = 16'hbbbb; exp[2] = 16'hcccc;
      for (int i = 0; i < 3; i++) cyc(1'b1, exp[i], 1'b0);
      n_cmp++;
      if (count !== 9'd3 || empty !== 1'b0) begin
         n_bad++; $display("FAIL basic_count: count=%0d empty=%b want 3 0", count, empty);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 16'h0, 1'b1);
         n_cmp++;
         if (dout !== exp[i] || dout_valid !== 1'b1) begin
            n_bad++; $display("FAIL basic_read%0d: dout=%h dv=%b want %h 1", i, dout, dout_valid, exp[i]);
         end
      end
      n_cmp++;
      if (empty !== 1'b1 || count !== 9'd0) begin
         n_bad++; $display("FAIL basic_empty: empty=%b count=%0d want 1 0", empty, count);
      end
      cyc(1'b0, 16'h0, 1'b0);
      n_cmp++;
      if (dout !== 16'hcccc || dout_valid !== 1'b0) begin
         n_bad++; $display("FAIL basic_hold: dout=%h dv=%b want cccc 0", dout, dout_valid);
      end
   endtask

   task automatic test_underflow;
      cyc(1'b0, 16'h0, 1'b1);
      n_cmp++;
      if (underflow !== 1'b1 || dout_valid !== 1'b0 || count !== 9'd0) begin
         n_bad++; $display("FAIL underflow_pulse: udf=%b dv=%b count=%0d want 1 0 0", underflow, dout_valid, count);
      end
      cyc(1'b0, 16'h0, 1'b0);
      n_cmp++;
      if (underflow !== 1'b0) begin
         n_bad++; $display("FAIL underflow_clear: udf=%b want 0", underflow);
      end
   endtask

   task automatic test_empty_rw;
      cyc(1'b1, 16'h5555, 1'b1);
      n_cmp++;
      if (underflow !== 1'b1 || dout_valid !== 1'b0 || count !== 9'd1 || dout !== 16'hcccc) begin
         n_bad++; $display("FAIL empty_rw: udf=%b dv=%b count=%0d dout=%h want 1 0 1 cccc",
                           underflow, dout_valid, count, dout);
      end
      cyc(1'b0, 16'h0, 1'b1);
      n_cmp++;
      if (dout !== 16'h5555 || dout_valid !== 1'b1 || empty !== 1'b1) begin
         n_bad++; $display("FAIL empty_rw_read: dout=%h dv=%b empty=%b want 5555 1 1", dout, dout_valid, empty);
      end
   endtask

   task automatic test_fill_wrap;
      logic [15:0] exp;
      int          bad_reads;
      for (int i = 0; i < 256; i++) cyc(1'b1, 16'(i), 1'b0);
      n_cmp++;
      if (full !== 1'b1 || count !== 9'd256 || empty !== 1'b0) begin
         n_bad++; $display("FAIL fill_full: full=%b count=%0d empty=%b want 1 256 0", full, count, empty);
      end
      cyc(1'b1, 16'hffff, 1'b0);
      n_cmp++;
      if (overflow !== 1'b1 || count !== 9'd256) begin
         n_bad++; $display("FAIL overflow_pulse: ovf=%b count=%0d want 1 256", overflow, count);
      end
      cyc(1'b0, 16'h0, 1'b0);
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL overflow_clear: ovf=%b want 0", overflow);
      end
      // Full with simultaneous read and write: pointers coincide, old word comes out.
      cyc(1'b1, 16'h1234, 1'b1);
      n_cmp++;
      if (dout !== 16'h0000 || dout_valid !== 1'b1 || count !== 9'd256 || full !== 1'b1 || overflow !== 1'b0) begin
         n_bad++; $display("FAIL full_rw: dout=%h dv=%b count=%0d full=%b ovf=%b want 0000 1 256 1 0",
                           dout, dout_valid, count, full, overflow);
      end
      bad_reads = 0;
      for (int i = 0; i < 256; i++) begin
         exp = (i == 255) ? 16'h1234 : 16'(i + 1);
         cyc(1'b0, 16'h0, 1'b1);
         n_cmp++;
         if (dout !== exp || dout_valid !== 1'b1) begin
            n_bad++; bad_reads++;
            if (bad_reads <= 8)
               $display("FAIL drain_%0d: dout=%h dv=%b want %h 1", i, dout, dout_valid, exp);
         end
      end
      n_cmp++;
      if (empty !== 1'b1 || count !== 9'd0 || full !== 1'b0) begin
         n_bad++; $display("FAIL drain_empty: empty=%b count=%0d full=%b want 1 0 0", empty, count, full);
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0a00 + 16'(i), 1'b0);
      cyc(1'b0, 16'h0, 1'b1);
      cyc(1'b0, 16'h0, 1'b1);
      n_cmp++;
      if (dout !== 16'h0a01 || count !== 9'd3) begin
         n_bad++; $display("FAIL pre_reset: dout=%h count=%0d want 0a01 3", dout, count);
      end
      @(negedge clk);
      rd_en = 1'b1;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (count !== 9'd0 || empty !== 1'b1 || full !== 1'b0 || dout !== 16'h0000 || dout_valid !== 1'b0) begin
         n_bad++; $display("FAIL async_reset: count=%0d empty=%b full=%b dout=%h dv=%b want 0 1 0 0000 0",
                           count, empty, full, dout, dout_valid);
      end
      @(negedge clk);
      rd_en = 1'b0;
      rst   = 1'b0;
      cyc(1'b0, 16'h0, 1'b1);
      n_cmp++;
      if (underflow !== 1'b1 || dout_valid !== 1'b0) begin
         n_bad++; $display("FAIL stale_unreachable: udf=%b dv=%b want 1 0", underflow, dout_valid);
      end
      cyc(1'b1, 16'hdddd, 1'b0);
      n_cmp++;
      if (count !== 9'd1) begin
         n_bad++; $display("FAIL post_reset_write: count=%0d want 1", count);
      end
      cyc(1'b0, 16'h0, 1'b1);
      n_cmp++;
      if (dout !== 16'hdddd || dout_valid !== 1'b1 || empty !== 1'b1) begin
         n_bad++; $display("FAIL post_reset_read: dout=%h dv=%b empty=%b want dddd 1 1", dout, dout_valid, empty);
      end
   endtask

`ifdef FIFO_ALMOST_FLAGS_EN
   task automatic test_almost;
      n_cmp++;
      if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
         n_bad++; $display("FAIL almost_idle: ae=%b af=%b want 1 0", almost_empty, almost_full);
      end
      for (int i = 0; i < 251; i++) cyc(1'b1, 16'(i), 1'b0);
      n_cmp++;
      if (almost_full !== 1'b0 || almost_empty !== 1'b0) begin
         n_bad++; $display("FAIL almost_251: af=%b ae=%b want 0 0", almost_full, almost_empty);
      end
      cyc(1'b1, 16'h0, 1'b0);
      n_cmp++;
      if (almost_full !== 1'b1 || count !== 9'd252) begin
         n_bad++; $display("FAIL almost_full_252: af=%b count=%0d want 1 252", almost_full, count);
      end
      for (int i = 0; i < 247; i++) cyc(1'b0, 16'h0, 1'b1);
      n_cmp++;
      if (almost_empty !== 1'b0 || count !== 9'd5) begin
         n_bad++; $display("FAIL almost_5: ae=%b count=%0d want 0 5", almost_empty, count);
      end
      cyc(1'b0, 16'h0, 1'b1);
      n_cmp++;
      if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
         n_bad++; $display("FAIL almost_empty_4: ae=%b af=%b want 1 0", almost_empty, almost_full);
      end
      for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1);
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_basic();
      test_underflow();
      test_empty_rw();
      test_fill_wrap();
      test_reset_mid();
`ifdef FIFO_ALMOST_FLAGS_EN
      test_almost();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
